// File: rtl/dmem_lane_ctrl.sv
// dmem_lane_ctrl: data-memory requester for four 8-bit byte-lane BRAMs
// (lane i holds byte i of every 32-bit word). One request in flight at a time:
// IDLE -> ISSUE -> RESP, one cycle each, so at most one request every 3 cycles.
// Ports: CLK/RST (async, active-high); REQ_* request with valid/ready handshake;
// RSP_* one-cycle response pulse, no backpressure; LANE_* per-lane BRAM strobes,
// byte addresses, write bytes and read bytes (BRAMs act on the falling edge).
// Build option: define DMEM_MISALIGN_EN to let misaligned half/word accesses
// complete, with each lane using its own word index. Without it they return RSP_ERR.
module dmem_lane_ctrl #(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    REQ_VALID,
  output logic                    REQ_READY,
  input  logic                    REQ_WE,
  input  logic [1:0]              REQ_SIZE,
  input  logic                    REQ_UNSIGNED,
  input  logic [ADDR_WIDTH-1:0]   REQ_ADDR,
  input  logic [31:0]             REQ_WDATA,
  output logic                    RSP_VALID,
  output logic [31:0]             RSP_RDATA,
  output logic                    RSP_ERR,
  output logic [4*ADDR_WIDTH-1:0] LANE_W_ADDR,
  output logic [4*ADDR_WIDTH-1:0] LANE_R_ADDR,
  output logic [3:0]              LANE_WE,
  output logic [3:0]              LANE_RE,
  output logic [31:0]             LANE_DIN,
  input  logic [31:0]             LANE_DOUT
);

  localparam int AW = ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            we_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;
  logic            err_q;

  logic            req_err;
  logic [2:0]      nbytes;
  logic [1:0]      lane_j    [4];  // which access byte lands on lane g
  logic            lane_act  [4];
  logic [AW-1:0]   lane_baddr[4];  // byte address of that access byte
  logic [1:0]      rd_lane   [4];  // which lane supplies access byte g
  logic [31:0]     asm_data;
  logic [31:0]     ext_data;

  // ---------------------------------------------------------------------------
  // Request decode (from the registered request)
  // ---------------------------------------------------------------------------
  always_comb begin
    nbytes = 3'd4;
    case (size_q)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  end

  always_comb begin
    req_err = (size_q == 2'b11);
`ifdef DMEM_MISALIGN_EN
    // Misaligned half/word accesses are legal; only the size encoding can fail.
`else
    if (size_q == 2'b01 && addr_q[0]) begin
      req_err = 1'b1;
    end
    if (size_q == 2'b10 && addr_q[1:0] != 2'b00) begin
      req_err = 1'b1;
    end
`endif
  end

  // Lane g carries access byte j = (g - A) mod 4; it is used when j < N.
  // The AW-bit add wraps the top word back to word 0.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign lane_j[g]     = 2'(g) - addr_q[1:0];
    assign lane_act[g]   = ({1'b0, lane_j[g]} < nbytes);
    assign lane_baddr[g] = addr_q + AW'(lane_j[g]);
    assign rd_lane[g]    = addr_q[1:0] + 2'(g);
    assign asm_data[8*g +: 8] = LANE_DOUT[{rd_lane[g], 3'b000} +: 8];
  end

  // ---------------------------------------------------------------------------
  // Lane strobes: only during ISSUE, and never for a rejected request. Because
  // they decode state_q directly, an async reset drops them at once.
  // ---------------------------------------------------------------------------
  always_comb begin
    LANE_WE     = '0;
    LANE_RE     = '0;
    LANE_W_ADDR = '0;
    LANE_R_ADDR = '0;
    LANE_DIN    = '0;
    if (state_q == ST_ISSUE && !req_err) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_act[i]) begin
          if (we_q) begin
            LANE_WE[i]            = 1'b1;
            LANE_W_ADDR[i*AW +: AW] = {lane_baddr[i][AW-1:2], 2'b00};
            LANE_DIN[8*i +: 8]    = wdata_q[{lane_j[i], 3'b000} +: 8];
          end else begin
            LANE_RE[i]            = 1'b1;
            LANE_R_ADDR[i*AW +: AW] = {lane_baddr[i][AW-1:2], 2'b00};
          end
        end
      end
    end
  end

  // Extend the assembled load to 32 bits; word loads pass through unchanged.
  always_comb begin
    ext_data = asm_data;
    case (size_q)
      2'b00:   ext_data = {{24{~uns_q & asm_data[7]}},  asm_data[7:0]};
      2'b01:   ext_data = {{16{~uns_q & asm_data[15]}}, asm_data[15:0]};
      default: ext_data = asm_data;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    REQ_READY = 1'b0;
    RSP_VALID = 1'b0;
    case (state_q)
      ST_IDLE: begin
        REQ_READY = 1'b1;
        if (REQ_VALID) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        RSP_VALID = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Response fields are only shown while RSP_VALID is high.
  assign RSP_RDATA = RSP_VALID ? rdata_q : 32'h0;
  assign RSP_ERR   = RSP_VALID & err_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && REQ_VALID) begin
        we_q    <= REQ_WE;
        size_q  <= REQ_SIZE;
        uns_q   <= REQ_UNSIGNED;
        addr_q  <= REQ_ADDR;
        wdata_q <= REQ_WDATA;
      end
      // LANE_DOUT is valid after the falling edge inside ISSUE; capture it here.
      if (state_q == ST_ISSUE) begin
        err_q   <= req_err;
        rdata_q <= (req_err || we_q) ? 32'h0 : ext_data;
      end
    end
  end

endmodule

// File: doc/dmem_lane_ctrl.md
Name: dmem_lane_ctrl

Overview:
- Data-memory requester for the four 8-bit byte-lane BRAMs (lane i holds byte i of each 32-bit word).
- Accepts core load/store requests over a valid/ready handshake.
- Generates per-lane word addresses, strobes and write bytes; assembles and extends read data.
- Returns one response per request; sits between the pipeline MEM stage and the lane BRAMs.

Parameters:
- ADDR_WIDTH, 13, byte-address width; lane BRAMs index with address bits [ADDR_WIDTH-1:2].

Ports:
- CLK  in  1  clock; FSM on rising edge; lane BRAMs act on the falling edge.
- RST  in  1  asynchronous, active-high reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  request accepted when REQ_VALID & REQ_READY at a rising edge.
- REQ_WE  in  1  1 = store, 0 = load.
- REQ_SIZE  in  2  00 byte, 01 half, 10 word, 11 illegal.
- REQ_UNSIGNED  in  1  load zero-extends when 1, sign-extends when 0.
- REQ_ADDR  in  ADDR_WIDTH  byte address.
- REQ_WDATA  in  32  store data, right-justified.
- RSP_VALID  out  1  one-cycle response pulse.
- RSP_RDATA  out  32  extended load data; 0 for stores and errors.
- RSP_ERR  out  1  request rejected; valid with RSP_VALID.
- LANE_W_ADDR  out  4*ADDR_WIDTH  per-lane write byte address, slice i = lane i, bits [1:0] = 0.
- LANE_R_ADDR  out  4*ADDR_WIDTH  per-lane read byte address, same format.
- LANE_WE  out  4  per-lane write enable.
- LANE_RE  out  4  per-lane read enable.
- LANE_DIN  out  32  byte i to lane i.
- LANE_DOUT  in  32  byte i from lane i; valid after the falling edge of the strobe cycle.

Behaviour:
- Reset: all outputs 0 except REQ_READY, which is 1 (FSM in IDLE). RST is asynchronous and active-high.
- FSM states: IDLE -> ISSUE -> RESP -> IDLE, one cycle each.
  - IDLE: REQ_READY=1. On handshake, register all REQ_* fields and go to ISSUE.
  - ISSUE: REQ_READY=0. Drive lane strobes and addresses from registers. At the next rising edge, capture LANE_DOUT, assemble and extend it into RSP_RDATA, set RSP_ERR, go to RESP.
  - RESP: RSP_VALID=1 for exactly one cycle; no backpressure. Return to IDLE.
- Timing: request accepted at edge k -> strobes high between k and k+1 -> RSP_VALID high between k+1 and k+2. Throughput is 1 request per 3 cycles; REQ_READY returns high after k+2.
- Lane mapping: access byte j (0..N-1, N = 1/2/4) uses lane L=(A+j) mod 4 and word index (A+j)>>2, taken mod 2^(ADDR_WIDTH-2).
  - The top word wraps to word 0.
  - Unused lanes: WE=RE=0, addresses 0, DIN byte 0.
- Store: LANE_WE[L]=1, LANE_DIN[L]=REQ_WDATA[8j+7:8j], LANE_W_ADDR slice L = word index<<2.
- Load: LANE_RE[L]=1, LANE_R_ADDR slice L set the same way. Assembled byte j = LANE_DOUT[L].
  - Bits above 8N are filled with 0 if REQ_UNSIGNED=1, else with bit 8N-1. Word loads ignore REQ_UNSIGNED.
- Errors: REQ_SIZE=11, or misaligned when the feature is disabled. Still passes through ISSUE/RESP with all strobes 0; RSP_ERR=1, RSP_RDATA=0.
- A store response has RSP_ERR=0 and RSP_RDATA=0.
- Reset mid-operation: FSM goes to IDLE, strobes drop immediately, no response is issued for the aborted request.

Optional Feature:
- Macro: DMEM_MISALIGN_EN.
- Defined: misaligned half/word accesses (A[0]=1 for half; A[1:0]!=0 for word) complete in a single ISSUE cycle. Lanes carry different word indices per the mapping above.
- Undefined: any misaligned access returns RSP_ERR=1 with no lane strobes.

Test Plan:
- Word store 0xDEADBEEF @0x010, then word load @0x010 -> LANE_WE=1111, all lane addresses 0x010; load RSP_RDATA=0xDEADBEEF, RSP_VALID exactly 2 cycles after accept.
- Byte load @0x013 of 0xDE, signed then unsigned -> lane 3 only; RSP_RDATA=0xFFFFFFDE, then 0x000000DE.
- Half store 0x8001 @0x012, signed half load -> LANE_WE=1100; RSP_RDATA=0xFFFF8001.
- REQ_SIZE=11 @0x000 -> no strobes; RSP_ERR=1, RSP_RDATA=0. Misaligned word @0x011 without the macro -> RSP_ERR=1.
- With DMEM_MISALIGN_EN, word load @0x1FFF (ADDR_WIDTH=13) -> lane 3 address 0x1FFC, lanes 0-2 address 0x0000 (wrap); data assembled in order.
- Assert RST during ISSUE -> strobes 0 immediately, no RSP_VALID, REQ_READY=1; the next request completes normally.
